// File: rtl/kb_typematic_fifo_pkg.sv
// ---------------------------------------------------------------------------
// kb_typematic_fifo_pkg
// Shared definitions for the keyboard typematic front-end:
//   - layout of one queued keyboard event (14 bits)
//   - one-hot encodings of the typematic FSM states
//   - a helper that packs an event word
// No ports; imported by kb_typematic_fifo.
// ---------------------------------------------------------------------------
package kb_typematic_fifo_pkg;

   // Event word layout: {rpt, flags[4:0], ascii[7:0]}
   localparam int KB_EVT_W         = 14;
   localparam int KB_EVT_ASCII_LSB = 0;
   localparam int KB_EVT_ASCII_MSB = 7;
   localparam int KB_EVT_FLAGS_LSB = 8;
   localparam int KB_EVT_FLAGS_MSB = 12;
   localparam int KB_EVT_RPT       = 13;

   typedef struct packed {
      logic       rpt;
      logic [4:0] flags;
      logic [7:0] ascii;
   } kb_evt_t;

   // Typematic FSM states, one-hot
   localparam logic [2:0] KB_IDLE   = 3'b001;
   localparam logic [2:0] KB_DELAY  = 3'b010;
   localparam logic [2:0] KB_REPEAT = 3'b100;

   function automatic logic [KB_EVT_W-1:0] kbPackEvent(input logic       rpt,
                                                       input logic [4:0] flags,
                                                       input logic [7:0] ascii);
      kb_evt_t evt;
      evt.rpt   = rpt;
      evt.flags = flags;
      evt.ascii = ascii;
      return evt;
   endfunction

endpackage

// File: rtl/kb_typematic_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
//   i_clk    system clock
//   i_rst    synchronous active-high reset (empties the FIFO)
//   i_push   write i_data this cycle
//   i_pop    remove the head this cycle (ignored when empty)
//   i_data   word to write
//   o_head   current head word, valid whenever o_empty is low
//   o_empty  no entries held
//   o_full   DEPTH entries held
//   o_count  number of entries held
//   o_drop   a push this cycle is being discarded (full with no pop)
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH  = 14,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [WIDTH-1:0]  i_data,
   output logic [WIDTH-1:0]  o_head,
   output logic              o_empty,
   output logic              o_full,
   output logic [ADDR_W:0]   o_count,
   output logic              o_drop
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wrPtr;
   logic [ADDR_W-1:0] r_rdPtr;
   logic [ADDR_W:0]   r_count;
   logic              w_pop;
   logic              w_write;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept
   // a push when it is also being read.
   always_comb begin
      o_empty = (r_count == '0);
      o_full  = (r_count == (ADDR_W+1)'(DEPTH));
      w_pop   = i_pop && !o_empty;
      w_write = i_push && (!o_full || w_pop);
      o_drop  = i_push && o_full && !w_pop;
      o_head  = r_mem[r_rdPtr];
      o_count = r_count;
   end

   // Storage array; contents need no reset because the pointers do.
   always_ff @(posedge i_clk) begin
      if (w_write) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_write) begin
            r_wrPtr <= r_wrPtr + (ADDR_W)'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + (ADDR_W)'(1);
         end
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/kb_typematic_fifo.sv
// ---------------------------------------------------------------------------
// kb_typematic_fifo
// Keyboard event front-end between kb_driver and the memory map. Each new
// key press queues one event; with auto-repeat enabled a held key queues a
// repeat event after DELAY_CYCLES and then every RATE_CYCLES. The CPU pops
// events from a FWFT FIFO through MMIO.
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_ascii_in   current key ASCII, 0 = no key held
//   i_flags_in   {is_error,is_special,is_capital,is_ctrl,is_shift}
//   i_repeat_en  1 = auto-repeat enabled
//   i_rd_en      pop pulse from the CPU read strobe
//   i_clr_ovf    clears the sticky overflow flag
//   o_rd_data    {18'd0, rpt, flags, ascii} of the FIFO head, 0 when empty
//   o_empty      FIFO empty
//   o_full       FIFO full
//   o_count      entries held
//   o_overflow   sticky: a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module kb_typematic_fifo
   import kb_typematic_fifo_pkg::*;
#(
   parameter int unsigned DELAY_CYCLES = 25000000,
   parameter int unsigned RATE_CYCLES  = 12500000,
   parameter int          DEPTH        = 16,
   parameter int          ADDR_W       = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_ascii_in,
   input  logic [4:0]        i_flags_in,
   input  logic              i_repeat_en,
   input  logic              i_rd_en,
   input  logic              i_clr_ovf,
   output logic [31:0]       o_rd_data,
   output logic              o_empty,
   output logic              o_full,
   output logic [ADDR_W:0]   o_count,
   output logic              o_overflow
);

   localparam logic [31:0] cDelay = 32'(DELAY_CYCLES);
   localparam logic [31:0] cRate  = 32'(RATE_CYCLES);

   logic [2:0]          r_state;
   logic [31:0]         r_timer;
   logic [7:0]          r_lastAscii;
   logic                r_overflow;

   logic [2:0]          w_nextState;
   logic [31:0]         w_nextTimer;
   logic                w_push;
   logic                w_rpt;
   logic                w_keyChanged;
   logic                w_drop;
   logic [KB_EVT_W-1:0] w_head;
   logic [KB_EVT_W-1:0] w_evt;

   // Typematic decision for this cycle. Release has priority over a key
   // change, which has priority over timer expiry, so at most one push is
   // requested per cycle. While repeat is off in DELAY the timer stops at
   // the delay value, so enabling repeat later fires immediately.
   always_comb begin
      w_nextState  = r_state;
      w_nextTimer  = r_timer;
      w_push       = 1'b0;
      w_rpt        = 1'b0;
      w_keyChanged = (i_ascii_in != r_lastAscii);
      case (r_state)
         KB_IDLE: begin
            w_nextTimer = '0;
            if (i_ascii_in != 8'd0) begin
               w_push      = 1'b1;
               w_nextState = KB_DELAY;
               w_nextTimer = 32'd1;
            end
         end
         KB_DELAY: begin
            if (i_ascii_in == 8'd0) begin
               w_nextState = KB_IDLE;
               w_nextTimer = '0;
            end else if (w_keyChanged) begin
               w_push      = 1'b1;
               w_nextTimer = 32'd1;
            end else if ((r_timer == cDelay) && i_repeat_en) begin
               w_push      = 1'b1;
               w_rpt       = 1'b1;
               w_nextState = KB_REPEAT;
               w_nextTimer = 32'd1;
            end else if (r_timer != cDelay) begin
               w_nextTimer = r_timer + 32'd1;
            end
         end
         KB_REPEAT: begin
            if (i_ascii_in == 8'd0) begin
               w_nextState = KB_IDLE;
               w_nextTimer = '0;
            end else if (w_keyChanged) begin
               w_push      = 1'b1;
               w_nextState = KB_DELAY;
               w_nextTimer = 32'd1;
            end else if (!i_repeat_en) begin
               w_nextState = KB_DELAY;
               w_nextTimer = 32'd1;
            end else if (r_timer == cRate) begin
               w_push      = 1'b1;
               w_rpt       = 1'b1;
               w_nextTimer = 32'd1;
            end else begin
               w_nextTimer = r_timer + 32'd1;
            end
         end
         default: begin
            w_nextState = KB_IDLE;
            w_nextTimer = '0;
         end
      endcase
      w_evt = kbPackEvent(w_rpt, i_flags_in, i_ascii_in);
   end

   // FSM registers plus the last pressed key used for change detection.
   // A key still held when reset releases is seen as a fresh press.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= KB_IDLE;
         r_timer     <= '0;
         r_lastAscii <= '0;
      end else begin
         r_state <= w_nextState;
         r_timer <= w_nextTimer;
         if (w_push && !w_rpt) begin
            r_lastAscii <= i_ascii_in;
         end
      end
   end

   // Sticky overflow; a dropping push wins over a simultaneous clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH  (KB_EVT_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_pop   (i_rd_en),
      .i_data  (w_evt),
      .o_head  (w_head),
      .o_empty (o_empty),
      .o_full  (o_full),
      .o_count (o_count),
      .o_drop  (w_drop)
   );

   // The head is only meaningful while the FIFO holds something.
   always_comb begin
      o_rd_data  = o_empty ? 32'd0 : {18'd0, w_head};
      o_overflow = r_overflow;
   end

endmodule

// File: tb/tb_kb_typematic_fifo.sv
// ---------------------------------------------------------------------------
// tb_kb_typematic_fifo
// Directed scenarios followed by randomized traffic for kb_typematic_fifo
// (DELAY_CYCLES=8, RATE_CYCLES=4, DEPTH=4). Expected outputs come from an
// event-deadline model with a queue standing in for the FIFO.
// ---------------------------------------------------------------------------
module tb_kb_typematic_fifo;

   localparam int D      = 8;
   localparam int R      = 4;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        ascii;
   logic [4:0]        flags;
   logic              ren;
   logic              rd;
   logic              clr;
   logic [31:0]       rdData;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              ovf;

   int passCount  = 0;
   int totalCount = 0;

   // Reference model state
   logic [13:0] mq[$];
   logic [7:0]  mHeld     = 8'd0;
   bit          mInRep    = 1'b0;
   int          mDeadline = 0;
   bit          mOvf      = 1'b0;
   int          cyc       = 0;

   always #5 clk = ~clk;

   kb_typematic_fifo #(
      .DELAY_CYCLES (D),
      .RATE_CYCLES  (R),
      .DEPTH        (DEPTH),
      .ADDR_W       (ADDR_W)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_ascii_in  (ascii),
      .i_flags_in  (flags),
      .i_repeat_en (ren),
      .i_rd_en     (rd),
      .i_clr_ovf   (clr),
      .o_rd_data   (rdData),
      .o_empty     (empty),
      .o_full      (full),
      .o_count     (count),
      .o_overflow  (ovf)
   );

   // One comparison; the pass counter is what the summary reports.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount = passCount + 1;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Behaviour of one clock edge: a held key has a deadline for its next
   // repeat; presses and key changes queue plain events, deadlines queue
   // repeat events, and the queue drops pushes when full with no pop.
   task automatic modelEdge(input logic r, input logic [7:0] a, input logic [4:0] f,
                            input logic re, input logic rdv, input logic c);
      bit push;
      bit rpt;
      bit pop;
      bit drop;
      push = 1'b0;
      rpt  = 1'b0;
      if (r) begin
         mq.delete();
         mHeld  = 8'd0;
         mInRep = 1'b0;
         mOvf   = 1'b0;
      end else begin
         if (mHeld == 8'd0) begin
            if (a != 8'd0) begin
               push = 1'b1; mHeld = a; mInRep = 1'b0; mDeadline = cyc + D;
            end
         end else if (a == 8'd0) begin
            mHeld = 8'd0;
         end else if (a != mHeld) begin
            push = 1'b1; mHeld = a; mInRep = 1'b0; mDeadline = cyc + D;
         end else if (!mInRep) begin
            if (re && cyc >= mDeadline) begin
               push = 1'b1; rpt = 1'b1; mInRep = 1'b1; mDeadline = cyc + R;
            end
         end else begin
            if (!re) begin
               mInRep = 1'b0; mDeadline = cyc + D;
            end else if (cyc >= mDeadline) begin
               push = 1'b1; rpt = 1'b1; mDeadline = cyc + R;
            end
         end
         pop  = rdv && (mq.size() > 0);
         drop = push && (mq.size() == DEPTH) && !pop;
         if (pop) void'(mq.pop_front());
         if (push && !drop) mq.push_back({rpt, f, a});
         if (drop) mOvf = 1'b1;
         else if (c) mOvf = 1'b0;
      end
   endtask

   task automatic checkModel();
      logic [31:0] expData;
      expData = (mq.size() > 0) ? {18'd0, mq[0]} : 32'd0;
      checkOutput("rd_data",  rdData, expData);
      checkOutput("count",    {29'd0, count}, 32'(mq.size()));
      checkOutput("empty",    {31'd0, empty}, {31'd0, (mq.size() == 0)});
      checkOutput("full",     {31'd0, full},  {31'd0, (mq.size() == DEPTH)});
      checkOutput("overflow", {31'd0, ovf},   {31'd0, mOvf});
   endtask

   // Drive one cycle of inputs, clock it, update the model, then check
   // outputs 1 time unit after the edge.
   task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [4:0] f,
                                input logic re, input logic rdv, input logic c);
      rst = r; ascii = a; flags = f; ren = re; rd = rdv; clr = c;
      @(posedge clk);
      modelEdge(r, a, f, re, rdv, c);
      cyc++;
      #1;
      checkModel();
   endtask

   task automatic holdKey(input logic [7:0] a, input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, a, 5'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      logic [7:0] curKey;
      int         holdLeft;
      rst = 1'b1; ascii = 8'd0; flags = 5'd0; ren = 1'b1; rd = 1'b0; clr = 1'b0;

      // Reset state
      applyStimulus(1'b1, 8'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("reset_rd_data", rdData, 32'd0);
      checkOutput("reset_empty", {31'd0, empty}, 32'd1);

      // Tap: one event, no repeat
      holdKey(8'h61, 3);
      holdKey(8'h00, 4);
      checkOutput("tap_head", rdData, 32'h61);
      checkOutput("tap_count", {29'd0, count}, 32'd1);
      drain(1);

      // Hold: events at +0,+8,+12,+16 fill the FIFO, the +20 push overflows
      holdKey(8'h61, 20);
      checkOutput("hold_full", {31'd0, full}, 32'd1);
      holdKey(8'h61, 1);
      checkOutput("ovf_set", {31'd0, ovf}, 32'd1);
      checkOutput("ovf_count", {29'd0, count}, 32'd4);
      checkOutput("ovf_head", rdData, 32'h61);
      applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      checkOutput("ovf_clr_count", {29'd0, count}, 32'd3);
      checkOutput("ovf_clr", {31'd0, ovf}, 32'd0);
      checkOutput("ovf_clr_head", rdData, 32'h2061);
      drain(3);

      // Key change without a gap
      holdKey(8'h61, 10);
      holdKey(8'h62, 9);
      checkOutput("chg_count", {29'd0, count}, 32'd4);
      drain(2);
      checkOutput("chg_press", rdData, 32'h62);
      drain(1);
      checkOutput("chg_repeat", rdData, 32'h2062);
      drain(1);

      // Push and pop together while full
      holdKey(8'h61, 20);
      applyStimulus(1'b0, 8'h61, 5'd0, 1'b1, 1'b1, 1'b0);
      checkOutput("sim_count", {29'd0, count}, 32'd4);
      checkOutput("sim_ovf", {31'd0, ovf}, 32'd0);
      drain(4);
      drain(1);
      checkOutput("rd_empty_count", {29'd0, count}, 32'd0);

      // Reset in REPEAT with three entries queued, key still held
      holdKey(8'h61, 13);
      checkOutput("pre_rst_count", {29'd0, count}, 32'd3);
      applyStimulus(1'b1, 8'h61, 5'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("rst_count", {29'd0, count}, 32'd0);
      checkOutput("rst_rd_data", rdData, 32'd0);
      holdKey(8'h61, 1);
      checkOutput("rst_repress", rdData, 32'h61);
      drain(2);

      // Randomized traffic
      curKey   = 8'd0;
      holdLeft = 0;
      for (int i = 0; i < 800; i++) begin
         if (holdLeft == 0) begin
            case ($urandom_range(0, 3))
               0:       curKey = 8'h00;
               1:       curKey = 8'h61;
               2:       curKey = 8'h62;
               default: curKey = 8'h63;
            endcase
            holdLeft = $urandom_range(1, 25);
         end
         holdLeft--;
         applyStimulus($urandom_range(0, 199) == 0, curKey, 5'($urandom),
                       $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) == 0);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
